// File: rtl/uart_hex_loader_pkg.sv
// Shared types and helpers for the UART hex loader:
// ASCII constants, FSM state enums, hex character decoding.
package yrv_loader_pkg;

    localparam logic [7:0] CHAR_AT    = 8'h40;
    localparam logic [7:0] CHAR_SLASH = 8'h2F;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [1:0] {
        TOKEN_IDLE,
        DATA,
        ADDR,
        COMMENT
    } token_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        CC_HEX,
        CC_AT,
        CC_SLASH,
        CC_LF,
        CC_OTHER
    } char_class_t;

    function automatic logic hex_digit_valid(
        input logic [7:0] c
    );
        return (c >= 8'h30 && c <= 8'h39)
            || (c >= 8'h41 && c <= 8'h46)
            || (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters a-f / A-F share low nibbles 1-6.
    function automatic logic [3:0] hex_digit_value(
        input logic [7:0] c
    );
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic char_class_t char_class(
        input logic [7:0] c
    );
        char_class_t cc;
        cc = CC_OTHER;
        unique case (1'b1)
            hex_digit_valid(c): cc = CC_HEX;
            c == CHAR_AT:       cc = CC_AT;
            c == CHAR_SLASH:    cc = CC_SLASH;
            c == CHAR_LF:       cc = CC_LF;
            default:            cc = CC_OTHER;
        endcase
        return cc;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop synchroniser.
// Ports: clk, reset_n, rx_i (async line), byte_o, byte_valid_o (1-cycle), stop_err_o (1-cycle).
module uart_rx_byte
    import yrv_loader_pkg::*;
#(
    parameter int BIT_CYCLES = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       stop_err_o
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CYCLES - 1);

    rx_state_t     state_q;
    logic          meta_q;
    logic          sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Synchroniser resets to idle-high so release never looks like a start edge.
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (sync_q) begin
                            valid_q <= 1'b1;
                            byte_q  <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign stop_err_o   = err_q;

endmodule

// File: rtl/uart_hex_loader.sv
// Loads ASCII hex text from UART into word memory, holding the MCU in reset meanwhile.
// Ports: clk, reset_n, rx, mem_we/mem_addr/mem_wdata, mcu_reset_n, loading, frame_err.
module uart_hex_loader
    import yrv_loader_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int ADDR_WIDTH    = 14,
    parameter int IDLE_TIMEOUT  = 5_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mcu_reset_n,
    output logic                  loading,
    output logic                  frame_err
);

    localparam int BIT_CYCLES =
        (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        stop_err;

    uart_rx_byte #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_i        (rx),
        .byte_o      (rx_byte),
        .byte_valid_o(byte_valid),
        .stop_err_o  (stop_err)
    );

    token_state_t          state_q;
    logic [31:0]           acc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TW-1:0]         tmo_q;
    logic                  loading_q;
    logic                  mcu_reset_n_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  frame_err_q;

    char_class_t cls;
    logic [3:0]  dig;
    logic        tmo_hit;
    logic        term;
    logic        wr;
    logic        set_addr;

    always_comb begin
        cls      = char_class(rx_byte);
        dig      = hex_digit_value(rx_byte);
        tmo_hit  = loading_q && !byte_valid
                && (tmo_q == TMO_LAST);
        // A timeout ends the pending token like a separator.
        term     = (byte_valid && cls != CC_HEX) || tmo_hit;
        wr       = term && (state_q == DATA);
        set_addr = term && (state_q == ADDR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= TOKEN_IDLE;
            acc_q         <= '0;
            addr_q        <= '0;
            tmo_q         <= '0;
            loading_q     <= 1'b0;
            mcu_reset_n_q <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_q | stop_err;

            mem_we_q <= wr;
            if (wr) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= acc_q;
            end

            if (byte_valid && !loading_q) begin
                addr_q <= '0;
            end else if (set_addr) begin
                addr_q <= acc_q[ADDR_WIDTH-1:0];
            end else if (wr) begin
                addr_q <= addr_q + 1'b1;
            end

            if (byte_valid || !loading_q || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (byte_valid) begin
                loading_q     <= 1'b1;
                mcu_reset_n_q <= 1'b0;
            end else if (tmo_hit) begin
                loading_q     <= 1'b0;
                mcu_reset_n_q <= 1'b1;
            end

            if (tmo_hit) begin
                state_q <= TOKEN_IDLE;
            end else if (byte_valid) begin
                if (state_q == COMMENT) begin
                    if (cls == CC_LF) begin
                        state_q <= TOKEN_IDLE;
                    end
                end else begin
                    unique case (cls)
                        CC_HEX: begin
                            if (state_q == TOKEN_IDLE) begin
                                acc_q   <= {28'd0, dig};
                                state_q <= DATA;
                            end else begin
                                acc_q <= {acc_q[27:0], dig};
                            end
                        end
                        CC_AT: begin
                            acc_q   <= '0;
                            state_q <= ADDR;
                        end
                        CC_SLASH: state_q <= COMMENT;
                        default:  state_q <= TOKEN_IDLE;
                    endcase
                end
            end
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mcu_reset_n = mcu_reset_n_q;
    assign loading     = loading_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed bench for uart_hex_loader with scaled-down timing.
// Writes are captured into a queue and compared with hand-computed lists.
module tb_uart_hex_loader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 62_500;
    localparam int BIT    = 16;
    localparam int AW     = 14;
    localparam int TMO    = 1000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mcu_reset_n;
    logic          loading;
    logic          frame_err;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] got_a[$];
    logic [31:0]   got_d[$];
    logic [AW-1:0] exp_a[$];
    logic [31:0]   exp_d[$];

    uart_hex_loader #(
        .CLK_FREQUENCY(CLK_HZ),
        .BAUD_RATE    (BAUD),
        .ADDR_WIDTH   (AW),
        .IDLE_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mcu_reset_n(mcu_reset_n),
        .loading    (loading),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_wdata);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a,
                          input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic chk_writes(input string tag);
        int n;
        chk({tag, " count"}, got_a.size(), exp_a.size());
        n = (got_a.size() < exp_a.size()) ?
            got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr%0d", tag, i), got_a[i], exp_a[i]);
            chk($sformatf("%s data%0d", tag, i), got_d[i], exp_d[i]);
        end
        got_a.delete();
        got_d.delete();
        exp_a.delete();
        exp_d.delete();
    endtask

    // Bit k ends at round((k+1)*p100/100) cycles after frame start.
    task automatic send_byte_p(input logic [7:0] b,
                               input int p100,
                               input logic stop);
        logic [9:0] fr;
        int t;
        int e;
        fr = {stop, b, 1'b0};
        t = 0;
        for (int k = 0; k < 10; k++) begin
            e = ((k + 1) * p100 + 50) / 100;
            rx = fr[k];
            while (t < e) begin
                @(negedge clk);
                t++;
            end
        end
        rx = 1'b1;
    endtask

    task automatic send_str_p(input string s, input int p100);
        for (int i = 0; i < s.len(); i++) begin
            send_byte_p(s[i], p100, 1'b1);
        end
    endtask

    task automatic send_str(input string s);
        send_str_p(s, BIT * 100);
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (loading === 1'b1 && n < TMO + 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, loading, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_we"}, mem_we, 1'b0);
        chk({tag, " mem_addr"}, mem_addr, '0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, " mcu_reset_n"}, mcu_reset_n, 1'b1);
        chk({tag, " loading"}, loading, 1'b0);
        chk({tag, " frame_err"}, frame_err, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: two data words, session timing
        send_str("DEADBEEF 12345678\n");
        chk("t1 loading on", loading, 1'b1);
        chk("t1 mcu_reset_n low", mcu_reset_n, 1'b0);
        repeat (TMO - 2 * BIT) @(negedge clk);
        chk("t1 loading held", loading, 1'b1);
        repeat (3 * BIT) @(negedge clk);
        chk("t1 loading off", loading, 1'b0);
        chk("t1 mcu_reset_n high", mcu_reset_n, 1'b1);
        exp_wr(14'h0000, 32'hDEADBEEF);
        exp_wr(14'h0001, 32'h12345678);
        chk_writes("t1");
        chk("t1 hold addr", mem_addr, 14'h0001);
        chk("t1 hold data", mem_wdata, 32'h12345678);

        // 2: address records, wrap, timeout write
        send_str("@10 a\n@3FFF 1 2");
        wait_end("t2 end");
        exp_wr(14'h0010, 32'h0000000A);
        exp_wr(14'h3FFF, 32'h00000001);
        exp_wr(14'h0000, 32'h00000002);
        chk_writes("t2");

        // 3: comment line skipped
        send_str("// x DEAD\nCafe");
        wait_end("t3 end");
        exp_wr(14'h0000, 32'h0000CAFE);
        chk_writes("t3");

        // 4: framing error
        send_byte_p(8'h41, BIT * 100, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        chk("t4 frame_err", frame_err, 1'b1);
        chk("t4 no session", loading, 1'b0);
        send_str("7 ");
        wait_end("t4 end");
        exp_wr(14'h0000, 32'h00000007);
        chk_writes("t4");
        chk("t4 frame_err sticky", frame_err, 1'b1);

        // 5: glitch rejected
        rx = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("t5 glitch loading", loading, 1'b0);
        chk_writes("t5 glitch");

        // 5: reset mid-byte inside a session
        send_str("12");
        chk("t5 session on", loading, 1'b1);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        chk_reset_vals("t5 midreset");
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_str("5\n");
        wait_end("t5 end");
        exp_wr(14'h0000, 32'h00000005);
        chk_writes("t5");

        // 6: baud tolerance, back-to-back
        send_str_p("1234 ", 1569);
        send_str_p("5678 ", 1633);
        wait_end("t6 end");
        exp_wr(14'h0000, 32'h00001234);
        exp_wr(14'h0001, 32'h00005678);
        chk_writes("t6");
        chk("t6 frame_err", frame_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
